// File: rtl/mouse_packet_ctrl.sv
// Groups PS/2 bytes into 3-byte mouse packets and decodes the buttons and the sign/magnitude velocity.
// Define MOUSE_PKT_CHECK_EN to require byte0 bit3 = 1 and to count framing errors in err_cnt.
module mouse_packet_ctrl #(
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int VSHIFT         = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       byte_ready,
  input  logic [7:0] byte_data,
  output logic       pkt_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_mid,
  output logic [9:0] vx,
  output logic [9:0] vy,
  output logic       dx,
  output logic       dy,
  output logic [1:0] state,
  output logic [7:0] err_cnt
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] C_TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_B1 = 2'd1, S_B2 = 2'd2, S_HOLD = 2'd3} state_t;

  state_t        r_state, w_next;
  logic          r_sync1, r_sync2, r_prev;
  logic          w_acc, w_timeout, w_b0_ok;
  logic          w_load_b0, w_decode, w_clr_vel;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_b0_hi;   // byte0[7:4]: y ovf, x ovf, y sign, x sign
  logic [2:0]    r_b0_btn;
  logic [7:0]    r_b1;
  logic          r_pkt_valid, r_btn_l, r_btn_r, r_btn_m, r_dx, r_dy;
  logic [9:0]    r_vx, r_vy;
  logic [8:0]    w_x, w_y, w_xmag, w_ymag;
  logic [7:0]    w_magx, w_magy, w_shx, w_shy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= byte_ready;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_acc     = r_sync2 & ~r_prev;
  assign w_timeout = (r_state != S_IDLE) && (r_cnt == C_TERM);

`ifdef MOUSE_PKT_CHECK_EN
  assign w_b0_ok = byte_data[3];
`else
  assign w_b0_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A byte arriving in the timeout cycle takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_acc && w_b0_ok) w_next = S_B1;
      S_B1: begin
        if (w_acc)          w_next = S_B2;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_B2: begin
        if (w_acc)          w_next = S_HOLD;
        else if (w_timeout) w_next = S_IDLE;
      end
      default: begin
        if (w_acc)          w_next = w_b0_ok ? S_B1 : S_IDLE;
        else if (w_timeout) w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_load_b0 = 1'b0;
    w_decode  = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE, S_HOLD: w_load_b0 = w_b0_ok;
        S_B2:           w_decode  = 1'b1;
        default:        ;
      endcase
    end
    w_clr_vel = (w_next != S_HOLD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          r_cnt <= '0;
    else if (w_acc || r_state == S_IDLE) r_cnt <= '0;
    else if (r_cnt != C_TERM)            r_cnt <= r_cnt + 1'b1;
  end

  // Byte2 is decoded straight off byte_data in its accept cycle.
  assign w_x    = {r_b0_hi[0], r_b1};
  assign w_y    = {r_b0_hi[1], byte_data};
  assign w_xmag = r_b0_hi[0] ? (~w_x + 9'd1) : w_x;
  assign w_ymag = r_b0_hi[1] ? (~w_y + 9'd1) : w_y;
  assign w_magx = (r_b0_hi[2] | w_xmag[8]) ? 8'hFF : w_xmag[7:0];
  assign w_magy = (r_b0_hi[3] | w_ymag[8]) ? 8'hFF : w_ymag[7:0];
  assign w_shx  = w_magx >> VSHIFT;
  assign w_shy  = w_magy >> VSHIFT;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_b0_hi     <= '0;
      r_b0_btn    <= '0;
      r_b1        <= '0;
      r_pkt_valid <= 1'b0;
      r_btn_l     <= 1'b0;
      r_btn_r     <= 1'b0;
      r_btn_m     <= 1'b0;
      r_dx        <= 1'b0;
      r_dy        <= 1'b0;
      r_vx        <= '0;
      r_vy        <= '0;
    end else begin
      r_pkt_valid <= w_decode;
      if (w_load_b0) begin
        r_b0_hi  <= byte_data[7:4];
        r_b0_btn <= byte_data[2:0];
      end
      if (w_acc && r_state == S_B1) r_b1 <= byte_data;
      if (w_decode) begin
        r_btn_l <= r_b0_btn[0];
        r_btn_r <= r_b0_btn[1];
        r_btn_m <= r_b0_btn[2];
        r_dx    <= ~r_b0_hi[0];
        r_dy    <= ~r_b0_hi[1];
        r_vx    <= {2'b00, w_shx};
        r_vy    <= {2'b00, w_shy};
      end else if (w_clr_vel) begin
        r_vx <= '0;
        r_vy <= '0;
      end
    end
  end

`ifdef MOUSE_PKT_CHECK_EN
  logic       w_err;
  logic [7:0] r_err_cnt;
  assign w_err = w_acc && (r_state == S_IDLE || r_state == S_HOLD) && !w_b0_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           r_err_cnt <= '0;
    else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign pkt_valid = r_pkt_valid;
  assign btn_left  = r_btn_l;
  assign btn_right = r_btn_r;
  assign btn_mid   = r_btn_m;
  assign vx        = r_vx;
  assign vy        = r_vy;
  assign dx        = r_dx;
  assign dy        = r_dy;
  assign state     = r_state;
endmodule
